// File: rtl/uart_cmd_assembler.sv
// Purpose: pairs UART RX bytes (high first) into 16-bit commands and forwards mux response bytes to UART TX.
// Latency: cmd/cmd_rdy one cycle after the low byte's rx_rdy; trmt one cycle after send_resp (idle) or tx_done (pending).
// Backpressure: none on RX (an unconsumed command is overwritten and flagged by overrun); TX holds one pending byte, last wins.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rx_rdy, rx_data            received byte from UART, held until clr_rx_rdy
//   clr_rx_rdy                 one-cycle acknowledge of a consumed byte
//   cmd, cmd_rdy, clr_cmd_rdy  assembled command, valid flag, consumer acknowledge
//   overrun                    sticky: a command completed while the previous one was unconsumed
//   send_resp, resp            request to transmit the mux response byte
//   trmt, tx_data, tx_done     transmit strobe/byte to UART and its completion
//
// Optional: define CMD_ASM_TIMEOUT_EN to discard a high byte whose low byte does not
// arrive within TIMEOUT_CYCLES clocks (TO_W-bit counter).
module uart_cmd_assembler #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned TO_W           = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        overrun,
    input  logic        send_resp,
    input  logic [7:0]  resp,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done
);

    typedef enum logic {WAIT_HIGH, WAIT_LOW} rx_state_t;
    typedef enum logic {TX_IDLE, TX_BUSY}    tx_state_t;

    rx_state_t rx_state;
    tx_state_t tx_state;
    logic [7:0] hi_byte;
    logic [7:0] pend_dat;
    logic       pending;
    logic       rx_take;
    logic       to_expire;

    // Elaboration guard: the counter must be able to reach TIMEOUT_CYCLES-1.
    if (TO_W < 1 || TO_W > 32 || (64'd1 << TO_W) < 64'(TIMEOUT_CYCLES)) begin : g_bad_cfg
        $error("uart_cmd_assembler: TO_W too small for TIMEOUT_CYCLES");
    end

    // The UART keeps rx_rdy high until it sees clr_rx_rdy, so the byte is
    // already consumed while our acknowledge is on the wire.
    assign rx_take = rx_rdy & ~clr_rx_rdy;

`ifdef CMD_ASM_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    assign to_expire = (rx_state == WAIT_LOW) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Held at zero outside WAIT_LOW, so it is clear on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (rx_state == WAIT_HIGH) begin
            to_cnt <= '0;
        end else if (!rx_rdy && !to_expire) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    assign to_expire = 1'b0;
`endif

    // RX assembly. Expiry takes priority over a byte arriving in the same
    // cycle; that byte stays on rx_rdy and is taken as a new high byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= WAIT_HIGH;
            hi_byte    <= 8'h00;
            cmd        <= 16'h0000;
            cmd_rdy    <= 1'b0;
            clr_rx_rdy <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            clr_rx_rdy <= 1'b0;
            if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end
            if (rx_state == WAIT_HIGH) begin
                if (rx_take) begin
                    hi_byte    <= rx_data;
                    clr_rx_rdy <= 1'b1;
                    rx_state   <= WAIT_LOW;
                end
            end else begin
                if (to_expire) begin
                    rx_state <= WAIT_HIGH;
                end else if (rx_take) begin
                    cmd        <= {hi_byte, rx_data};
                    cmd_rdy    <= 1'b1;   // overrides a same-cycle clear
                    clr_rx_rdy <= 1'b1;
                    if (cmd_rdy && !clr_cmd_rdy) begin
                        overrun <= 1'b1;
                    end
                    rx_state <= WAIT_HIGH;
                end
            end
        end
    end

    // TX response path with a single-entry, last-wins pending slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            trmt     <= 1'b0;
            tx_data  <= 8'h00;
            pending  <= 1'b0;
            pend_dat <= 8'h00;
        end else begin
            trmt <= 1'b0;
            if (tx_state == TX_IDLE) begin
                if (send_resp) begin
                    tx_data  <= resp;
                    trmt     <= 1'b1;
                    tx_state <= TX_BUSY;
                end
            end else begin
                if (tx_done) begin
                    if (pending) begin
                        tx_data <= pend_dat;
                        trmt    <= 1'b1;
                        pending <= send_resp;
                        if (send_resp) begin
                            pend_dat <= resp;
                        end
                    end else if (send_resp) begin
                        tx_data <= resp;
                        trmt    <= 1'b1;
                    end else begin
                        tx_state <= TX_IDLE;
                    end
                end else if (send_resp) begin
                    pend_dat <= resp;
                    pending  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Purpose: self-checking bench for uart_cmd_assembler using expectation queues for RX commands and TX bytes.
// Latency: checks cmd/cmd_rdy and trmt appear exactly one cycle after the triggering input.
// Backpressure: exercises overrun, same-cycle set/clear, pending-byte overwrite and mid-operation reset.
module tb_uart_cmd_assembler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        overrun;
    logic        send_resp = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;

    always #10 clk = ~clk;

    uart_cmd_assembler #(.TIMEOUT_CYCLES(100), .TO_W(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .overrun(overrun),
        .send_resp(send_resp), .resp(resp),
        .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_low;
        logic [15:0] cmd;
    } rx_exp_t;

    rx_exp_t    rx_q[$];
    logic [7:0] tx_q[$];
    rx_exp_t    mon_rx;
    logic [7:0] mon_tx;

    // Reference model state
    bit         m_have_hi = 1'b0;
    logic [7:0] m_hi = 8'h00;
    bit         m_busy = 1'b0;
    bit         m_pend = 1'b0;
    logic [7:0] m_pend_dat = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: every acknowledge and transmit strobe must match an expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (clr_rx_rdy) begin
                if (rx_q.size() == 0) begin
                    check_eq("rx_unexpected_ack", clr_rx_rdy, 1'b0);
                end else begin
                    mon_rx = rx_q.pop_front();
                    if (mon_rx.is_low) begin
                        check_eq("cmd_value", cmd, mon_rx.cmd);
                        check_eq("cmd_rdy_set", cmd_rdy, 1'b1);
                    end
                end
            end
            if (trmt) begin
                if (tx_q.size() == 0) begin
                    check_eq("tx_unexpected_trmt", trmt, 1'b0);
                end else begin
                    mon_tx = tx_q.pop_front();
                    check_eq("tx_data", tx_data, mon_tx);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit clr_with);
        bit got = 1'b0;
        if (!m_have_hi) begin
            rx_q.push_back('{1'b0, 16'h0000});
            m_hi      = b;
            m_have_hi = 1'b1;
        end else begin
            rx_q.push_back('{1'b1, {m_hi, b}});
            m_have_hi = 1'b0;
        end
        rx_data     = b;
        rx_rdy      = 1'b1;
        clr_cmd_rdy = clr_with;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            clr_cmd_rdy = 1'b0;
            if (clr_rx_rdy) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check_eq("clr_rx_rdy_timeout", clr_rx_rdy, 1'b1);
        // UART drops rx_rdy only after seeing the acknowledge.
        @(posedge clk); #1;
        rx_rdy = 1'b0;
    endtask

    task automatic clear_cmd();
        clr_cmd_rdy = 1'b1;
        @(posedge clk); #1;
        clr_cmd_rdy = 1'b0;
        check_eq("cmd_rdy_cleared", cmd_rdy, 1'b0);
    endtask

    task automatic req(input logic [7:0] r);
        bit exp_t = !m_busy;
        if (!m_busy) begin
            tx_q.push_back(r);
            m_busy = 1'b1;
        end else begin
            m_pend     = 1'b1;
            m_pend_dat = r;
        end
        send_resp = 1'b1;
        resp      = r;
        @(posedge clk); #1;
        send_resp = 1'b0;
        check_eq("trmt_after_req", trmt, exp_t);
    endtask

    task automatic done();
        bit exp_t = m_pend;
        if (m_pend) begin
            tx_q.push_back(m_pend_dat);
            m_pend = 1'b0;
        end else begin
            m_busy = 1'b0;
        end
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        check_eq("trmt_after_done", trmt, exp_t);
    endtask

    task automatic done_req(input logic [7:0] r);
        if (m_pend) begin
            tx_q.push_back(m_pend_dat);
            m_pend_dat = r;
        end else begin
            tx_q.push_back(r);
        end
        tx_done   = 1'b1;
        send_resp = 1'b1;
        resp      = r;
        @(posedge clk); #1;
        tx_done   = 1'b0;
        send_resp = 1'b0;
        check_eq("trmt_after_done_req", trmt, 1'b1);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_cmd", cmd, 16'h0000);
        check_eq("rst_cmd_rdy", cmd_rdy, 1'b0);
        check_eq("rst_clr_rx_rdy", clr_rx_rdy, 1'b0);
        check_eq("rst_trmt", trmt, 1'b0);
        check_eq("rst_overrun", overrun, 1'b0);
        check_eq("rst_tx_data", tx_data, 8'h00);
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        rx_q.delete();
        tx_q.delete();
        m_have_hi = 1'b0;
        m_busy = 1'b0;
        m_pend = 1'b0;
        rx_rdy = 1'b0;
        send_resp = 1'b0;
        tx_done = 1'b0;
        clr_cmd_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: basic assembly and acknowledge
        send_byte(8'h29, 1'b0);
        send_byte(8'h01, 1'b0);
        check_eq("t1_cmd", cmd, 16'h2901);
        clear_cmd();
        check_eq("t1_overrun", overrun, 1'b0);

        // 2a: overrun when the previous command was not consumed
        send_byte(8'h20, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h3B, 1'b0);
        send_byte(8'hF2, 1'b0);
        check_eq("t2_cmd", cmd, 16'h3BF2);
        check_eq("t2_cmd_rdy", cmd_rdy, 1'b1);
        check_eq("t2_overrun", overrun, 1'b1);

        // 2b: completion coincident with clr_cmd_rdy: set wins, no overrun
        do_reset();
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b1);
        check_eq("t2b_cmd_rdy_held", cmd_rdy, 1'b1);
        check_eq("t2b_overrun", overrun, 1'b0);
        check_eq("t2b_cmd", cmd, 16'h7788);
        clear_cmd();

        // 3: immediate transmit, then last-wins pending
        req(8'h5A);
        req(8'h5A);
        req(8'hA5);
        done();

        // 4: tx_done with send_resp, nothing pending: immediate, stays busy
        done_req(8'hA5);
        req(8'h11);
        done();
        done();
        req(8'h22);
        done();

        // 5: timeout between high and low byte
        do_reset();
        send_byte(8'h21, 1'b0);
        repeat (100) @(posedge clk);
        #1;
`ifdef CMD_ASM_TIMEOUT_EN
        m_have_hi = 1'b0;
`endif
        send_byte(8'h30, 1'b0);
        send_byte(8'h00, 1'b0);
`ifdef CMD_ASM_TIMEOUT_EN
        check_eq("t5_cmd_timeout", cmd, 16'h3000);
`else
        check_eq("t5_cmd_no_timeout", cmd, 16'h2130);
`endif

        // 6: reset in WAIT_LOW with a pending TX byte
        if (!m_have_hi) send_byte(8'h44, 1'b0);
        req(8'h12);
        req(8'h34);
        do_reset();
        send_byte(8'hC3, 1'b0);
        send_byte(8'h3C, 1'b0);
        check_eq("t6_cmd", cmd, 16'hC33C);
        done();
        repeat (10) @(posedge clk);
        #1;
        check_eq("t6_trmt_quiet", trmt, 1'b0);

        check_eq("rx_queue_drained", rx_q.size(), 0);
        check_eq("tx_queue_drained", tx_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
